// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared types for the register-file writeback path.
//   REG_W     : register file word width
//   rf_addr_t : 5-bit register index, carried as bits [6:2] of the instruction field
//   wb_req_t  : a writeback request (destination + data)
//   is_x0()   : true for the hard-wired zero register
package rf_pkg;

  localparam int REG_W = 32;

  typedef logic [6:2] rf_addr_t;

  typedef struct packed {
    rf_addr_t         rd;
    logic [REG_W-1:0] data;
  } wb_req_t;

  function automatic logic is_x0(rf_addr_t a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_if: bundle of every handshake/bus signal around the writeback arbiter.
//   ALU stream   : alu_valid/alu_ready/alu_rd/alu_data
//   LSU stream   : lsu_valid/lsu_ready/lsu_rd/lsu_data
//   load issue   : issue_en/issue_rd -> issue_ready, sb_busy (scoreboard view)
//   RF write     : wen/waddr/wdata (registered)
//   RF read side : raddr1/2, rf_rdata1/2 (raw RF data) -> rdata1/2 (to pipeline)
// Modports: slave = the arbiter, master = the surrounding core (or a bench).
interface rf_wb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  rf_addr_t          alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  rf_addr_t          lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              issue_en;
  rf_addr_t          issue_rd;
  logic              issue_ready;
  logic [31:0]       sb_busy;
  logic              wen;
  rf_addr_t          waddr;
  logic [DATA_W-1:0] wdata;
  rf_addr_t          raddr1;
  rf_addr_t          raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_en, issue_rd,
    input  raddr1, raddr2, rf_rdata1, rf_rdata2,
    output alu_ready, lsu_ready, issue_ready, sb_busy,
    output wen, waddr, wdata, rdata1, rdata2
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_en, issue_rd,
    output raddr1, raddr2, rf_rdata1, rf_rdata2,
    input  alu_ready, lsu_ready, issue_ready, sb_busy,
    input  wen, waddr, wdata, rdata1, rdata2
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: one pending-load bit per architectural register.
// Ports:
//   clk, srst    : core clock, synchronous active-high reset (clears all bits)
//   issue_en/rd  : load being issued to rd; sets busy[rd] when issue_ready and rd!=0
//   clr_en/rd    : load data accepted for rd; clears busy[rd]
//   issue_ready  : comb, low when rd already has a load in flight (x0 always ready)
//   busy         : registered busy vector, bit 0 is constant 0
// A set and a clear hitting the same register in one cycle leave it set: the new
// load's data is still outstanding.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        issue_en,
  input  rf_addr_t    issue_rd,
  input  logic        clr_en,
  input  rf_addr_t    clr_rd,
  output logic        issue_ready,
  output logic [31:0] busy
);

  logic [31:0] busy_reg;
  logic [31:0] busy_next;
  logic        set_en;

  assign issue_ready = !busy_reg[issue_rd] || is_x0(issue_rd);
  assign set_en      = issue_en && issue_ready && !is_x0(issue_rd);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (set_en && issue_rd == rf_addr_t'(gi)) ? 1'b1 :
                               (clr_en && clr_rd == rf_addr_t'(gi))   ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU and LSU writeback streams onto the register
// file's single synchronous write port, tracks in-flight loads, and optionally
// forwards the write in progress to the RF's async read ports.
// Ports:
//   clk, srst : core clock, synchronous active-high reset
//   wb        : rf_wb_if.slave (ALU/LSU handshakes, load issue + scoreboard,
//               registered RF write port, RF read-data path)
// Parameters: DATA_W (must match the RF word width), MAX_STALL (1..15).
// Build option: define RF_WB_BYPASS_EN to forward wdata onto rdata1/2 when the
// read address matches the write being performed this cycle.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 4
) (
  input  logic   clk,
  input  logic   srst,
  rf_wb_if.slave wb
);

  logic              alu_ready;
  logic              lsu_ready;
  logic              alu_acc;
  logic              lsu_acc;
  logic              stall_max;
  rf_addr_t          sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              do_write;

  logic [3:0]        stall_cnt_reg;
  logic [3:0]        stall_cnt_next;
  logic              wen_reg;
  rf_addr_t          waddr_reg;
  logic [DATA_W-1:0] wdata_reg;

  // LSU normally wins; after MAX_STALL refused ALU cycles the ALU gets one slot.
  assign stall_max = (stall_cnt_reg == 4'(MAX_STALL));

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!srst) begin
      if (stall_max) begin
        alu_ready = 1'b1;
      end else begin
        lsu_ready = 1'b1;
        alu_ready = !wb.lsu_valid;
      end
    end
  end

  assign alu_acc = wb.alu_valid && alu_ready;
  assign lsu_acc = wb.lsu_valid && lsu_ready;

  // Readies are mutually exclusive whenever both streams are valid, so at most
  // one request is accepted per cycle.
  assign sel_rd   = lsu_acc ? wb.lsu_rd   : wb.alu_rd;
  assign sel_data = lsu_acc ? wb.lsu_data : wb.alu_data;
  assign do_write = (alu_acc || lsu_acc) && !is_x0(sel_rd);

  always_comb begin
    stall_cnt_next = 4'd0;
    if (wb.alu_valid && !alu_ready) begin
      stall_cnt_next = stall_max ? stall_cnt_reg : stall_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      stall_cnt_reg <= 4'd0;
      wen_reg       <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      wen_reg       <= do_write;
      if (do_write) begin
        waddr_reg <= sel_rd;
        wdata_reg <= sel_data;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk         (clk),
    .srst        (srst),
    .issue_en    (wb.issue_en),
    .issue_rd    (wb.issue_rd),
    .clr_en      (lsu_acc),
    .clr_rd      (wb.lsu_rd),
    .issue_ready (wb.issue_ready),
    .busy        (wb.sb_busy)
  );

  assign wb.alu_ready = alu_ready;
  assign wb.lsu_ready = lsu_ready;
  assign wb.wen       = wen_reg;
  assign wb.waddr     = waddr_reg;
  assign wb.wdata     = wdata_reg;

`ifdef RF_WB_BYPASS_EN
  // The RF only commits at the end of the wen cycle, so its async read still
  // shows the old value; forward the pending write instead.
  assign wb.rdata1 = (wen_reg && waddr_reg == wb.raddr1 && !is_x0(wb.raddr1)) ?
                     wdata_reg : wb.rf_rdata1;
  assign wb.rdata2 = (wen_reg && waddr_reg == wb.raddr2 && !is_x0(wb.raddr2)) ?
                     wdata_reg : wb.rf_rdata2;
`else
  assign wb.rdata1 = wb.rf_rdata1;
  assign wb.rdata2 = wb.rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the writeback rules.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int MAX_STALL = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  rf_wb_if #(.DATA_W(32)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .MAX_STALL(MAX_STALL)) dut (
    .clk  (clk),
    .srst (srst),
    .wb   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: what the RF write port and scoreboard should show.
  int          m_stall;     // consecutive cycles the ALU was refused
  logic        m_wen;
  rf_addr_t    m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  bit          m_after_rst;
  bit          alu_pend, lsu_pend;
  int          alu_pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check comb outputs mid-cycle, advance model at the edge,
  // check registered outputs just after it. Inputs must already be driven.
  task automatic step();
    logic        e_ar, e_lr, e_ir, a_acc, l_acc;
    logic [31:0] e_rd1, e_rd2;
    #4;
    if (srst) begin
      e_ar = 1'b0; e_lr = 1'b0;
    end else if (m_stall >= MAX_STALL) begin
      e_ar = 1'b1; e_lr = 1'b0;
    end else begin
      e_lr = 1'b1; e_ar = !bus.lsu_valid;
    end
    e_ir  = !m_busy[bus.issue_rd] || (bus.issue_rd == 0);
    e_rd1 = (BYP && m_wen && m_waddr == bus.raddr1 && bus.raddr1 != 0) ? m_wdata : bus.rf_rdata1;
    e_rd2 = (BYP && m_wen && m_waddr == bus.raddr2 && bus.raddr2 != 0) ? m_wdata : bus.rf_rdata2;
    check_eq("alu_ready", 32'(bus.alu_ready), 32'(e_ar));
    check_eq("lsu_ready", 32'(bus.lsu_ready), 32'(e_lr));
    check_eq("issue_ready", 32'(bus.issue_ready), 32'(e_ir));
    check_eq("rdata1", bus.rdata1, e_rd1);
    check_eq("rdata2", bus.rdata2, e_rd2);
    if (bus.alu_ready === 1'b1) alu_pulses++;
    a_acc    = bus.alu_valid && e_ar;
    l_acc    = bus.lsu_valid && e_lr;
    alu_pend = bus.alu_valid && !e_ar;
    lsu_pend = bus.lsu_valid && !e_lr;
    @(posedge clk);
    if (srst) begin
      m_stall = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_after_rst = 1;
      $display("cycle reset");
    end else begin
      m_after_rst = 0;
      m_wen = 0;
      if (l_acc) begin
        m_busy[bus.lsu_rd] = 1'b0;
        if (bus.lsu_rd != 0) begin
          m_wen = 1; m_waddr = bus.lsu_rd; m_wdata = bus.lsu_data;
        end
        $display("wb lsu rd=%0d data=%h", bus.lsu_rd, bus.lsu_data);
      end else if (a_acc) begin
        if (bus.alu_rd != 0) begin
          m_wen = 1; m_waddr = bus.alu_rd; m_wdata = bus.alu_data;
        end
        $display("wb alu rd=%0d data=%h", bus.alu_rd, bus.alu_data);
      end else begin
        $display("idle");
      end
      if (bus.issue_en && e_ir && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      m_stall = (bus.alu_valid && !e_ar) ? ((m_stall + 1 > MAX_STALL) ? MAX_STALL : m_stall + 1) : 0;
    end
    #1;
    check_eq("wen", 32'(bus.wen), 32'(m_wen));
    check_eq("sb_busy", bus.sb_busy, m_busy);
    if (m_wen || m_after_rst) begin
      check_eq("waddr", 32'(bus.waddr), 32'(m_waddr));
      check_eq("wdata", bus.wdata, m_wdata);
    end
  endtask

  task automatic idle_inputs();
    srst = 0;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_en = 0; bus.issue_rd = '0;
    bus.raddr1 = '0; bus.raddr2 = '0; bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
  endtask

  initial begin
    m_stall = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    m_after_rst = 0; alu_pend = 0; lsu_pend = 0; alu_pulses = 0;
    idle_inputs();
    srst = 1;
    #1;
    step(); step();
    srst = 0;

    // 1: ALU-only write, then idle
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEAD_BEEF;
    step();
    check_eq("t1_wen", 32'(bus.wen), 32'd1);
    check_eq("t1_wdata", bus.wdata, 32'hDEAD_BEEF);
    idle_inputs();
    step();

    // 2: collision, ALU served once after MAX_STALL refusals
    alu_pulses = 0;
    bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h0000_4444;
    bus.alu_rd = 3; bus.alu_data = 32'h0000_3333;
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = (i <= 4);
      step();
    end
    check_eq("t2_alu_pulses", 32'(alu_pulses), 32'd1);
    idle_inputs();
    step();

    // 3: scoreboard set, blocked re-issue, clear, same-cycle set+clear
    bus.issue_en = 1; bus.issue_rd = 7;
    step();
    check_eq("t3_busy7", 32'(bus.sb_busy[7]), 32'd1);
    step();                               // re-issue refused
    bus.issue_en = 0;
    bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h7777;
    step();
    check_eq("t3_busy7_clr", 32'(bus.sb_busy[7]), 32'd0);
    bus.lsu_rd = 8; bus.issue_en = 1; bus.issue_rd = 8;
    step();
    check_eq("t3_busy8_setwins", 32'(bus.sb_busy[8]), 32'd1);
    idle_inputs();

    // 4: x0 writes and issues are invisible
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 1;
    bus.issue_en = 1; bus.issue_rd = 0;
    step();
    check_eq("t4_wen", 32'(bus.wen), 32'd0);
    idle_inputs();

    // 5: read-after-write forwarding
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'h55;
    step();
    idle_inputs();
    bus.raddr1 = 9; bus.rf_rdata1 = 32'h0;
    step();

    // 6: reset in the middle of traffic
    idle_inputs();
    bus.issue_en = 1; bus.issue_rd = 2;
    step();
    bus.issue_en = 0;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h2222;
    step();
    srst = 1;
    step();
    check_eq("t6_wen", 32'(bus.wen), 32'd0);
    check_eq("t6_busy", bus.sb_busy, 32'd0);
    idle_inputs();
    step();

    // Random traffic; a refused request is held unchanged until accepted.
    alu_pend = 0; lsu_pend = 0;
    for (int c = 0; c < 400; c++) begin
      srst = ($urandom_range(0, 59) == 0);
      if (!alu_pend) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_rd    = rf_addr_t'($urandom_range(0, 7));
        bus.alu_data  = $urandom;
      end
      if (!lsu_pend) begin
        bus.lsu_valid = ($urandom_range(0, 3) != 0);
        bus.lsu_rd    = rf_addr_t'($urandom_range(0, 7));
        bus.lsu_data  = $urandom;
      end
      bus.issue_en  = $urandom_range(0, 1);
      bus.issue_rd  = rf_addr_t'($urandom_range(0, 7));
      bus.raddr1    = rf_addr_t'($urandom_range(0, 7));
      bus.raddr2    = rf_addr_t'($urandom_range(0, 7));
      bus.rf_rdata1 = $urandom;
      bus.rf_rdata2 = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
